// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and default sizes for the data-memory arbiter.
//                Provides the owner encoding used by the picker and by the
//                read-return tag, plus default widths and lock limit.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int c_ADDR_W   = 8;
    localparam int c_DATA_W   = 8;
    localparam int c_LOCK_MAX = 4;

    // Which requester owns (or last owned) the memory port.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Counter width able to hold values 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the two requester ports (A = CPU, B = debug/loader)
//                and the single-port memory interface.
//                slave  : arbiter view (requests in, grants/returns/memory out)
//                master : environment view (requesters plus memory)
//  Ports       : a_req/a_we/a_addr/a_wdata -> a_gnt/a_rvalid/a_rdata
//                b_req/b_we/b_addr/b_wdata/b_lock -> b_gnt/b_rvalid/b_rdata
//                mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_lock;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rr_pick
//  Description : Two-way round-robin picker with a bounded lock for port B.
//                Grant decision is combinational; last owner and the lock
//                counter are the only state.
//  Ports       : clk, reset (async, active-high)
//                i_a_req, i_b_req, i_b_lock  requests and B lock
//                o_gnt_a, o_gnt_b            one-hot (or zero) grants
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = c_LOCK_MAX
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_a_req,
    input  wire logic i_b_req,
    input  wire logic i_b_lock,
    output logic      o_gnt_a,
    output logic      o_gnt_b
);

    localparam int                 c_CNT_W   = cnt_width(LOCK_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(LOCK_MAX);

    owner_t             r_last_owner;
    logic [c_CNT_W-1:0] r_lock_cnt;

    logic w_hold_lock;
    logic w_pick_a;
    logic w_pick_b;

    always_comb begin
        w_pick_a    = 1'b0;
        w_pick_b    = 1'b0;
        // B keeps the port on conflict only while it is the current owner,
        // still asks for the lock, and has not used up its budget.
        w_hold_lock = (r_last_owner == OWN_B) && i_b_lock && (r_lock_cnt < c_CNT_MAX);

        if (i_a_req && !i_b_req) begin
            w_pick_a = 1'b1;
        end else if (!i_a_req && i_b_req) begin
            w_pick_b = 1'b1;
        end else if (i_a_req && i_b_req) begin
            if (w_hold_lock) begin
                w_pick_b = 1'b1;
            end else if (r_last_owner == OWN_B) begin
                w_pick_a = 1'b1;
            end else begin
                w_pick_b = 1'b1;
            end
        end

        // Grants are suppressed for as long as reset is held.
        o_gnt_a = w_pick_a && !reset;
        o_gnt_b = w_pick_b && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWN_B;
            r_lock_cnt   <= '0;
        end else begin
            if (w_pick_a) begin
                r_last_owner <= OWN_A;
            end else if (w_pick_b) begin
                r_last_owner <= OWN_B;
            end

            // Counter only measures B grants that actually made A wait.
            if (w_pick_a || !i_b_lock || !i_b_req) begin
                r_lock_cnt <= '0;
            end else if (w_pick_b && i_a_req && (r_lock_cnt < c_CNT_MAX)) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares a single-port data memory between port A (CPU) and
//                port B (debug/loader). One access per cycle, round-robin on
//                conflict, bounded lock for B bursts, and routing of the
//                1-cycle-latency read data back to the issuing port.
//  Ports       : clk    clock, rising edge
//                reset  asynchronous, active-high
//                bus    dmem_arbiter_if.slave (requesters + memory)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int LOCK_MAX = c_LOCK_MAX
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Read-return tracking: r_pend marks a read issued last cycle, r_tag
    // says who issued it. Returns are always exactly one cycle behind.
    logic   r_pend;
    owner_t r_tag;
    logic   w_a_rvalid;
    logic   w_b_rvalid;

    dmem_rr_pick #(
        .LOCK_MAX (LOCK_MAX)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .i_a_req  (bus.a_req),
        .i_b_req  (bus.b_req),
        .i_b_lock (bus.b_lock),
        .o_gnt_a  (w_gnt_a),
        .o_gnt_b  (w_gnt_b)
    );

    always_comb begin
        w_mem_en    = w_gnt_a || w_gnt_b;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt_a) begin
            w_mem_we    = bus.a_we;
            w_mem_addr  = bus.a_addr;
            w_mem_wdata = bus.a_wdata;
        end else if (w_gnt_b) begin
            w_mem_we    = bus.b_we;
            w_mem_addr  = bus.b_addr;
            w_mem_wdata = bus.b_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_tag  <= OWN_A;
        end else begin
            r_pend <= w_mem_en && !w_mem_we;
            if (w_mem_en) begin
                r_tag <= w_gnt_a ? OWN_A : OWN_B;
            end
        end
    end

    assign w_a_rvalid = r_pend && (r_tag == OWN_A);
    assign w_b_rvalid = r_pend && (r_tag == OWN_B);

    assign bus.a_gnt     = w_gnt_a;
    assign bus.b_gnt     = w_gnt_b;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    // Memory data is fed straight through, zeroed unless it belongs to the port.
    assign bus.a_rvalid  = w_a_rvalid;
    assign bus.b_rvalid  = w_b_rvalid;
    assign bus.a_rdata   = w_a_rvalid ? bus.mem_rdata : '0;
    assign bus.b_rdata   = w_b_rvalid ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a simple
//                1-cycle-latency memory model attached to the memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .LOCK_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Single-port memory: write on strobe, read data one cycle later.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic drive_a(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata, input logic lock);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_lock = lock;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 8'h03, 8'h33);
        drive_b(1'b1, 1'b1, 8'h04, 8'h44, 1'b0);
        #1;
        n_checks++; if (bus.a_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_a_gnt: got %b want 0", bus.a_gnt); end
        n_checks++; if (bus.b_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_b_gnt: got %b want 0", bus.b_gnt); end
        n_checks++; if (bus.mem_en !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
        n_checks++; if (bus.mem_we !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_a_rvalid: got %b want 0", bus.a_rvalid); end
        n_checks++; if (bus.b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_b_rvalid: got %b want 0", bus.b_rvalid); end
        n_checks++; if (bus.a_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_a_rdata: got %h want 00", bus.a_rdata); end
        n_checks++; if (bus.b_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_b_rdata: got %h want 00", bus.b_rdata); end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // After reset last_owner is B, so a conflict goes to A first.
    task automatic test_first_conflict();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 8'h01, 8'h11);
        drive_b(1'b1, 1'b1, 8'h02, 8'h22, 1'b0);
        #1;
        n_checks++; if (bus.a_gnt !== 1'b1)     begin n_fail++; $display("FAIL conf1_a_gnt: got %b want 1", bus.a_gnt); end
        n_checks++; if (bus.b_gnt !== 1'b0)     begin n_fail++; $display("FAIL conf1_b_gnt: got %b want 0", bus.b_gnt); end
        n_checks++; if (bus.mem_addr !== 8'h01) begin n_fail++; $display("FAIL conf1_addr: got %h want 01", bus.mem_addr); end
        n_checks++; if (bus.mem_we !== 1'b1)    begin n_fail++; $display("FAIL conf1_we: got %b want 1", bus.mem_we); end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1)      begin n_fail++; $display("FAIL conf2_b_gnt: got %b want 1", bus.b_gnt); end
        n_checks++; if (bus.a_gnt !== 1'b0)      begin n_fail++; $display("FAIL conf2_a_gnt: got %b want 0", bus.a_gnt); end
        n_checks++; if (bus.mem_addr !== 8'h02)  begin n_fail++; $display("FAIL conf2_addr: got %h want 02", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h22) begin n_fail++; $display("FAIL conf2_wdata: got %h want 22", bus.mem_wdata); end
        @(negedge clk);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_a_write_read();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 8'h10, 8'h5A);
        #1;
        n_checks++; if (bus.a_gnt !== 1'b1)      begin n_fail++; $display("FAIL wr_a_gnt: got %b want 1", bus.a_gnt); end
        n_checks++; if (bus.mem_en !== 1'b1)     begin n_fail++; $display("FAIL wr_mem_en: got %b want 1", bus.mem_en); end
        n_checks++; if (bus.mem_we !== 1'b1)     begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 8'h10)  begin n_fail++; $display("FAIL wr_addr: got %h want 10", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL wr_wdata: got %h want 5a", bus.mem_wdata); end
        @(negedge clk);
        drive_a(1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        n_checks++; if (bus.a_gnt !== 1'b1)    begin n_fail++; $display("FAIL rd_a_gnt: got %b want 1", bus.a_gnt); end
        n_checks++; if (bus.mem_we !== 1'b0)   begin n_fail++; $display("FAIL rd_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.a_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", bus.a_rvalid); end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.a_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_a_rvalid: got %b want 1", bus.a_rvalid); end
        n_checks++; if (bus.a_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_a_rdata: got %h want 5a", bus.a_rdata); end
        n_checks++; if (bus.b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_b_rvalid: got %b want 0", bus.b_rvalid); end
        n_checks++; if (bus.mem_en !== 1'b0)   begin n_fail++; $display("FAIL idle_mem_en: got %b want 0", bus.mem_en); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_a_rvalid_once: got %b want 0", bus.a_rvalid); end
    endtask

    // last_owner is A here, so continuous conflict yields B,A,B,A,...
    task automatic test_alternate();
        int cnt_a = 0;
        int cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_a(1'b1, 1'b1, 8'h30, 8'(i));
            drive_b(1'b1, 1'b1, 8'h31, 8'(i + 8'h80), 1'b0);
            #1;
            if (bus.a_gnt === 1'b1) cnt_a++;
            if (bus.b_gnt === 1'b1) cnt_b++;
            n_checks++;
            if (bus.b_gnt !== ((i % 2) == 0) || bus.a_gnt !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL alt_gnt[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, (i % 2) == 1, (i % 2) == 0);
            end
        end
        n_checks++; if (cnt_a != 4 || cnt_b != 4) begin n_fail++; $display("FAIL alt_share: got a=%0d b=%0d want 4/4", cnt_a, cnt_b); end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_lock_burst();
        // B takes the port alone; lock count stays 0 because A is not waiting.
        @(negedge clk);
        drive_b(1'b1, 1'b1, 8'h40, 8'h77, 1'b1);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first_b: got %b want 1", bus.b_gnt); end
        // A waits: four locked B grants, then A.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_a(1'b1, 1'b1, 8'h41, 8'h99);
            #1;
            n_checks++;
            if (bus.b_gnt !== (i < 4) || bus.a_gnt !== (i == 4)) begin
                n_fail++;
                $display("FAIL lock_burst[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, i == 4, i < 4);
            end
        end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_b_alone: got %b want 1", bus.b_gnt); end
        // Counter was cleared by the A grant: locked B wins the next conflict.
        @(negedge clk);
        drive_a(1'b1, 1'b1, 8'h41, 8'h99);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_cleared: got a=%b b=%b want a=0 b=1", bus.a_gnt, bus.b_gnt); end
        // Without lock, round-robin hands the conflict to A.
        @(negedge clk);
        bus.b_lock = 1'b0;
        #1;
        n_checks++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin n_fail++; $display("FAIL unlock_rr: got a=%b b=%b want a=1 b=0", bus.a_gnt, bus.b_gnt); end
        // Leave B as last owner.
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_tail_b: got %b want 1", bus.b_gnt); end
        @(negedge clk);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back_reads();
        @(negedge clk);
        drive_a(1'b1, 1'b0, 8'h01, 8'h00);
        drive_b(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        #1;
        n_checks++; if (bus.a_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_a_gnt: got %b want 1", bus.a_gnt); end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1)    begin n_fail++; $display("FAIL b2b_b_gnt: got %b want 1", bus.b_gnt); end
        n_checks++; if (bus.a_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_a_rvalid: got %b want 1", bus.a_rvalid); end
        n_checks++; if (bus.a_rdata !== 8'h11) begin n_fail++; $display("FAIL b2b_a_rdata: got %h want 11", bus.a_rdata); end
        n_checks++; if (bus.b_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_b_rvalid0: got %b want 0", bus.b_rvalid); end
        @(negedge clk);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        n_checks++; if (bus.b_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_b_rvalid: got %b want 1", bus.b_rvalid); end
        n_checks++; if (bus.b_rdata !== 8'h22) begin n_fail++; $display("FAIL b2b_b_rdata: got %h want 22", bus.b_rdata); end
        n_checks++; if (bus.a_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_a_rvalid0: got %b want 0", bus.a_rvalid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_b(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        #1;
        n_checks++; if (bus.b_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_b_gnt: got %b want 1", bus.b_gnt); end
        @(negedge clk);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive_a(1'b1, 1'b1, 8'h05, 8'h55);
        reset = 1'b1;
        #1;
        n_checks++; if (bus.b_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_b_rvalid: got %b want 0", bus.b_rvalid); end
        n_checks++; if (bus.b_rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_b_rdata: got %h want 00", bus.b_rdata); end
        n_checks++; if (bus.a_gnt !== 1'b0)    begin n_fail++; $display("FAIL midrst_a_gnt: got %b want 0", bus.a_gnt); end
        n_checks++; if (bus.mem_en !== 1'b0)   begin n_fail++; $display("FAIL midrst_mem_en: got %b want 0", bus.mem_en); end
        @(negedge clk);
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst[%0d]: got a_rv=%b b_rv=%b en=%b want 0/0/0", i, bus.a_rvalid, bus.b_rvalid, bus.mem_en);
            end
        end
    endtask

    initial begin
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_first_conflict();
        test_a_write_read();
        test_alternate();
        test_lock_burst();
        test_back_to_back_reads();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
